// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator: walks the operands MSB-first, one bit per clock,
// with optional two's-complement mode and early termination on the first differing bit.
module serial_mag_comparator #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned EARLY_EXIT = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   signed_mode,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    output logic                   busy,
    output logic                   done,
    output logic                   a_gt_b,
    output logic                   a_lt_b,
    output logic                   a_eq_b,
    output logic [$clog2(WIDTH):0] bits_used
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        COMPARE
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] a_q, b_q, a_d, b_d;
    logic             sm_q, sm_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pend_gt_q, pend_lt_q, pend_gt_d, pend_lt_d;
    logic             busy_d, done_d, gt_d, lt_d, eq_d;
    logic [CNT_W-1:0] bits_used_d;

    logic bit_a, bit_b, sign_pos, bit_gt, bit_lt, gt_now, lt_now, last;

    // Per-bit decision; the sign bit flips polarity in signed mode, and an earlier
    // decision always takes precedence over the current bit.
    always_comb begin
        bit_a    = a_q[idx_q];
        bit_b    = b_q[idx_q];
        sign_pos = sm_q && (idx_q == IDX_MSB);
        bit_gt   = sign_pos ? (!bit_a && bit_b) : (bit_a && !bit_b);
        bit_lt   = sign_pos ? (bit_a && !bit_b) : (!bit_a && bit_b);
        gt_now   = pend_gt_q || (!(pend_gt_q || pend_lt_q) && bit_gt);
        lt_now   = pend_lt_q || (!(pend_gt_q || pend_lt_q) && bit_lt);
        last     = (idx_q == '0) || ((EARLY_EXIT != 0) && (gt_now || lt_now));
    end

    always_comb begin
        state_d     = state;
        a_d         = a_q;
        b_d         = b_q;
        sm_d        = sm_q;
        idx_d       = idx_q;
        pend_gt_d   = pend_gt_q;
        pend_lt_d   = pend_lt_q;
        busy_d      = busy;
        done_d      = 1'b0;
        gt_d        = a_gt_b;
        lt_d        = a_lt_b;
        eq_d        = a_eq_b;
        bits_used_d = bits_used;

        case (state)
            IDLE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    sm_d      = signed_mode;
                    idx_d     = IDX_MSB;
                    pend_gt_d = 1'b0;
                    pend_lt_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = COMPARE;
                end
            end
            COMPARE: begin
                if (last) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    gt_d        = gt_now;
                    lt_d        = lt_now;
                    eq_d        = !(gt_now || lt_now);
                    bits_used_d = CNT_W'(WIDTH) - CNT_W'(idx_q);
                end else begin
                    idx_d     = idx_q - IDX_W'(1);
                    pend_gt_d = gt_now;
                    pend_lt_d = lt_now;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sm_q      <= 1'b0;
            idx_q     <= '0;
            pend_gt_q <= 1'b0;
            pend_lt_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            a_gt_b    <= 1'b0;
            a_lt_b    <= 1'b0;
            a_eq_b    <= 1'b0;
            bits_used <= '0;
        end else begin
            state     <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sm_q      <= sm_d;
            idx_q     <= idx_d;
            pend_gt_q <= pend_gt_d;
            pend_lt_q <= pend_lt_d;
            busy      <= busy_d;
            done      <= done_d;
            a_gt_b    <= gt_d;
            a_lt_b    <= lt_d;
            a_eq_b    <= eq_d;
            bits_used <= bits_used_d;
        end
    end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Bench for serial_mag_comparator: an early-exit and a constant-latency instance share
// stimulus and are checked against an arithmetic reference of result and latency.
module tb_serial_mag_comparator;

    localparam int unsigned W    = 8;
    localparam int unsigned BU_W = $clog2(W) + 1;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] a, b;

    logic            busy0, done0, gt0, lt0, eq0;
    logic            busy1, done1, gt1, lt1, eq1;
    logic [BU_W-1:0] bu0, bu1;

    // status word per instance: {busy, done, gt, lt, eq, bits_used[3:0]}
    logic [8:0] st [2];
    assign st[0] = {busy0, done0, gt0, lt0, eq0, bu0};
    assign st[1] = {busy1, done1, gt1, lt1, eq1, bu1};

    int         n_checks = 0;
    int         n_fail   = 0;
    int         exp_n    [2];
    logic [2:0] exp_res  [2];
    logic [2:0] held_res [2];
    logic [3:0] held_bu  [2];

    serial_mag_comparator #(.WIDTH(W), .EARLY_EXIT(1)) dut_ee (
        .clock(clock), .reset(reset), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy0), .done(done0), .a_gt_b(gt0), .a_lt_b(lt0),
        .a_eq_b(eq0), .bits_used(bu0)
    );

    serial_mag_comparator #(.WIDTH(W), .EARLY_EXIT(0)) dut_cl (
        .clock(clock), .reset(reset), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy1), .done(done1), .a_gt_b(gt1), .a_lt_b(lt1),
        .a_eq_b(eq1), .bits_used(bu1)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int d, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
        end
    endtask

    function automatic logic [2:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic s);
        int sx, sy;
        if (s) begin
            sx = $signed(x);
            sy = $signed(y);
        end else begin
            sx = int'(x);
            sy = int'(y);
        end
        return {sx > sy, sx < sy, sx == sy};
    endfunction

    function automatic int ref_latency(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input bit early);
        if (!early || x == y) return W;
        for (int k = W - 1; k >= 0; k--)
            if (x[k] != y[k]) return W - k;
        return W;
    endfunction

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        a           = x;
        b           = y;
        signed_mode = s;
        start       = 1'b1;
        for (int d = 0; d < 2; d++) begin
            exp_n[d]   = ref_latency(x, y, d == 0);
            exp_res[d] = ref_result(x, y, s);
        end
    endtask

    // Called mid-cycle with start raised; follows both instances to completion.
    task automatic run_one(input int pulse_at);
        int got_n [2];
        got_n = '{0, 0};
        @(posedge clock); #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        for (int d = 0; d < 2; d++) begin
            check("accept_busy", d, 32'(st[d][8]), 32'd1);
            check("accept_done", d, 32'(st[d][7]), 32'd0);
        end
        for (int c = 1; c <= W + 2 && (got_n[0] == 0 || got_n[1] == 0); c++) begin
            @(posedge clock); #1;
            for (int d = 0; d < 2; d++) begin
                if (got_n[d] != 0) begin
                    check("done_pulse_width", d, 32'(st[d][8:7]), 32'd0);
                end else if (st[d][7]) begin
                    got_n[d] = c;
                    check("latency", d, 32'(c), 32'(exp_n[d]));
                    check("result", d, 32'(st[d][6:4]), 32'(exp_res[d]));
                    check("bits_used", d, 32'(st[d][3:0]), 32'(exp_n[d]));
                    check("busy_at_done", d, 32'(st[d][8]), 32'd0);
                    held_res[d] = exp_res[d];
                    held_bu[d]  = 4'(exp_n[d]);
                end else begin
                    check("busy_during", d, 32'(st[d][8]), 32'd1);
                    check("result_hold", d, 32'({st[d][6:4], st[d][3:0]}),
                          32'({held_res[d], held_bu[d]}));
                end
            end
            if (c == pulse_at - 1) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'h00;
            end
            if (c == pulse_at) start = 1'b0;
        end
        for (int d = 0; d < 2; d++)
            if (got_n[d] == 0) check("done_timeout", d, 32'd0, 32'd1);
    endtask

    initial begin
        logic [W-1:0] x, y;
        reset       = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;
        for (int d = 0; d < 2; d++) begin
            held_res[d] = '0;
            held_bu[d]  = '0;
        end

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;
        for (int d = 0; d < 2; d++) check("reset_idle", d, 32'(st[d]), 32'd0);

        launch(8'h80, 8'h7F, 1'b0); run_one(0);
        launch(8'h80, 8'h7F, 1'b1); run_one(0);
        launch(8'hFF, 8'hFE, 1'b1); run_one(0);
        launch(8'h5A, 8'h5A, 1'b0); run_one(0);
        launch(8'h40, 8'h00, 1'b0); run_one(0);
        launch(8'h01, 8'h02, 1'b0); run_one(3);

        // constant-latency instance is on its done cycle here; start now must be taken
        check("b2b_done_cycle", 1, 32'(st[1][7]), 32'd1);
        launch(8'h7E, 8'h81, 1'b1); run_one(0);

        for (int i = 0; i < 40; i++) begin
            x = W'($urandom);
            case ($urandom_range(0, 3))
                0:       y = x;
                1:       y = x ^ W'(1 << $urandom_range(0, W - 1));
                default: y = W'($urandom);
            endcase
            launch(x, y, 1'($urandom_range(0, 1)));
            run_one(0);
        end

        // abort an 8-cycle compare partway through
        launch(8'h03, 8'h02, 1'b0);
        @(posedge clock); #1 start = 1'b0;
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) check("midop_reset", d, 32'(st[d]), 32'd0);
        repeat (2) begin
            @(posedge clock); #1;
            for (int d = 0; d < 2; d++) check("reset_no_done", d, 32'(st[d][7]), 32'd0);
        end
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            held_res[d] = '0;
            held_bu[d]  = '0;
        end
        @(posedge clock); #1;
        for (int d = 0; d < 2; d++) check("post_reset_idle", d, 32'(st[d]), 32'd0);
        launch(8'h10, 8'h10, 1'b0); run_one(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
